// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared widths, defaults and state type for the APB transfer scheduler
package apb_bridge_pkg;
  localparam int ADDR_W        = 32;
  localparam int DATA_W        = 32;
  localparam int DEF_NSLV      = 4;
  localparam int DEF_SLV_SHIFT = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DERR
  } sched_state_t;
endpackage

// File: rtl/apb_xfer_scheduler_if.sv
// rtl/apb_xfer_scheduler_if.sv - FIFO read side, APB master bus and status signals of the scheduler
interface apb_xfer_scheduler_if #(
  parameter int NSLV = apb_bridge_pkg::DEF_NSLV
);
  import apb_bridge_pkg::*;

  logic              rempty;
  logic [ADDR_W-1:0] fifo_addr;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_write;
  logic              rinc;
  logic [NSLV-1:0]   Psel;
  logic              Penable;
  logic              Pwrite;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pdata;
  logic              Pready;
  logic [DATA_W-1:0] Prdata;
  logic [DATA_W-1:0] rdata_out;
  logic              rdata_valid;
  logic              decode_err;
  logic              timeout_err;
  logic              busy;

  modport master (
    input  rempty, fifo_addr, fifo_data, fifo_write, Pready, Prdata,
    output rinc, Psel, Penable, Pwrite, Paddr, Pdata,
           rdata_out, rdata_valid, decode_err, timeout_err, busy
  );

  modport slave (
    output rempty, fifo_addr, fifo_data, fifo_write, Pready, Prdata,
    input  rinc, Psel, Penable, Pwrite, Paddr, Pdata,
           rdata_out, rdata_valid, decode_err, timeout_err, busy
  );
endinterface

// File: rtl/apb_addr_decode.sv
// rtl/apb_addr_decode.sv - combinational address decode to {hit, one-hot slave select}
module apb_addr_decode
  import apb_bridge_pkg::*;
#(
  parameter int                NSLV      = DEF_NSLV,
  parameter int                SLV_SHIFT = DEF_SLV_SHIFT,
  parameter logic [ADDR_W-1:0] BASE_HI   = 32'h4000_0000 >> (SLV_SHIFT + $clog2(NSLV))
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [NSLV-1:0]   sel
);
  localparam int IDXW = $clog2(NSLV);

  logic [IDXW-1:0] idx;

  assign idx = addr[SLV_SHIFT +: IDXW];
  assign hit = (addr >> (SLV_SHIFT + IDXW)) == BASE_HI;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      sel[i] = hit && (idx == IDXW'(i));
    end
  end
endmodule

// File: rtl/apb_xfer_scheduler.sv
// rtl/apb_xfer_scheduler.sv - FIFO-driven APB IDLE/SETUP/ACCESS sequencer
// Optional ACCESS timeout abort is built when APB_SCHED_TIMEOUT_EN is defined.
module apb_xfer_scheduler
  import apb_bridge_pkg::*;
#(
  parameter int                NSLV      = DEF_NSLV,
  parameter int                SLV_SHIFT = DEF_SLV_SHIFT,
  parameter logic [ADDR_W-1:0] BASE_HI   = 32'h4000_0000 >> (SLV_SHIFT + $clog2(NSLV))
`ifdef APB_SCHED_TIMEOUT_EN
  , parameter int              TO_CYCLES = 16
`endif
) (
  input  logic                 Pclk,
  input  logic                 Preset,
  apb_xfer_scheduler_if.master bus
);
  sched_state_t      state;
  sched_state_t      state_nxt;
  logic              capture;
  logic              abort;
  logic              done_read;
  logic              dec_hit;
  logic [NSLV-1:0]   dec_sel;
  logic [NSLV-1:0]   sel_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              pwrite_q;
  logic              rvalid_q;

  apb_addr_decode #(
    .NSLV      (NSLV),
    .SLV_SHIFT (SLV_SHIFT),
    .BASE_HI   (BASE_HI)
  ) u_decode (
    .addr (bus.fifo_addr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

`ifdef APB_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TO_CYCLES) + 1;

  logic [CNT_W-1:0] wait_cnt;
  logic             tout_q;

  // Counts ACCESS wait cycles; SETUP always precedes ACCESS so it is the clear point.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      wait_cnt <= '0;
      tout_q   <= 1'b0;
    end else begin
      tout_q <= abort;
      if (state == ST_SETUP) begin
        wait_cnt <= '0;
      end else if (state == ST_ACCESS && !bus.Pready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign abort = (state == ST_ACCESS) && !bus.Pready && (wait_cnt == CNT_W'(TO_CYCLES - 1));
  assign bus.timeout_err = tout_q;
`else
  assign abort = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign done_read = (state == ST_ACCESS) && bus.Pready && !pwrite_q;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      ST_IDLE:   capture = !bus.rempty;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.Pready) begin
          capture   = !bus.rempty;
          state_nxt = ST_IDLE;
        end else if (abort) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DERR:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    // No pop while reset is held, otherwise an entry would vanish unexecuted.
    if (Preset) begin
      capture = 1'b0;
    end
    if (capture) begin
      state_nxt = dec_hit ? ST_SETUP : ST_DERR;
    end
  end

  always_ff @(posedge Pclk) begin
    if (Preset) begin
      state    <= ST_IDLE;
      sel_q    <= '0;
      paddr_q  <= '0;
      pdata_q  <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      rvalid_q <= done_read;
      if (done_read) begin
        rdata_q <= bus.Prdata;
      end
      if (capture) begin
        paddr_q  <= bus.fifo_addr;
        pdata_q  <= bus.fifo_data;
        pwrite_q <= bus.fifo_write;
        sel_q    <= dec_sel;
      end
    end
  end

  assign bus.rinc        = capture;
  assign bus.Psel        = (state == ST_SETUP || state == ST_ACCESS) ? sel_q : '0;
  assign bus.Penable     = (state == ST_ACCESS);
  assign bus.Pwrite      = pwrite_q;
  assign bus.Paddr       = paddr_q;
  assign bus.Pdata       = pdata_q;
  assign bus.rdata_out   = rdata_q;
  assign bus.rdata_valid = rvalid_q;
  assign bus.decode_err  = (state == ST_DERR);
  assign bus.busy        = (state != ST_IDLE);
endmodule

// File: doc/apb_xfer_scheduler.md
# apb_xfer_scheduler

Single-clock APB transfer sequencer on the read side of the bridge's async FIFO. It pops one queued AHB request (address, data, direction) at a time and decodes the address to one of NSLV APB slaves. It then runs the APB IDLE/SETUP/ACCESS protocol with Pready wait states and returns read data. It replaces the free-running `transfer`/`write_enable` control of the current APB master with a FIFO-driven scheduler.

## Interface
- NSLV, 4, number of APB slaves (power of two, 2..16); IDXW = log2(NSLV)
- SLV_SHIFT, 12, LSB of the slave-index field in the address
- BASE_HI, 20'h4000_0 >> IDXW (i.e. upper bits), required value of Paddr[31:SLV_SHIFT+IDXW] for a hit
- TO_CYCLES, 16, ACCESS-state cycle limit before timeout (only with macro)
- Pclk  in  1  APB clock, all state on rising edge
- Preset  in  1  reset, synchronous, active-high
- rempty  in  1  FIFO empty; fifo_* valid whenever low (first-word-fall-through)
- fifo_addr  in  32  queued address
- fifo_data  in  32  queued write data
- fifo_write  in  1  queued direction, 1 = write
- rinc  out  1  FIFO pop strobe, one cycle per entry
- Psel  out  NSLV  one-hot slave select
- Penable  out  1  APB enable
- Pwrite  out  1  APB direction
- Paddr  out  32  APB address
- Pdata  out  32  APB write data
- Pready  in  1  slave ready
- Prdata  in  32  slave read data
- rdata_out  out  32  captured read data
- rdata_valid  out  1  one-cycle pulse, rdata_out valid
- decode_err  out  1  one-cycle pulse, popped entry missed every slave
- timeout_err  out  1  one-cycle pulse, ACCESS abandoned
- busy  out  1  state != IDLE

## Operation
- States: IDLE, SETUP, ACCESS, DERR.
- Capture: when state is IDLE, or ACCESS with Pready=1, and rempty=0: rinc=1 (combinational), and Paddr/Pdata/Pwrite, slave index, and hit flag are registered from fifo_*.
  - Next state is SETUP on a hit, DERR on a miss.
- Hit = (fifo_addr[31:SLV_SHIFT+IDXW] == BASE_HI). Index = fifo_addr[SLV_SHIFT+IDXW-1:SLV_SHIFT].
- SETUP: Psel[index]=1, Penable=0. Next state is always ACCESS.
- ACCESS: Psel held, Penable=1. Stays while Pready=0.
  - On Pready=1 with Pwrite=0: rdata_out<=Prdata and rdata_valid=1 next cycle.
  - On Pready=1: capture the next entry if present, else go to IDLE.
- DERR: decode_err=1, Psel=0, no APB cycle. Next state is IDLE. The entry is discarded.
- Paddr/Pdata/Pwrite hold their last values in IDLE. Psel=0 and Penable=0 in IDLE and DERR.
- Entries are never reordered. No pop occurs while rempty=1.

## Timing
- Reset (Preset=1 at an edge): state IDLE; Psel, Penable, Pwrite, rinc, rdata_valid, decode_err, timeout_err = 0; Paddr, Pdata, rdata_out = 0.
- Reset mid-transfer: Psel/Penable drop at that edge. The popped entry is lost and is not retried.
- Latency from rempty falling in IDLE:
  - rinc in the same cycle.
  - SETUP in cycle +1.
  - ACCESS in cycle +2.
  - With Pready=1, completion at the end of cycle +2 and rdata_valid in cycle +3.
- Back-to-back with Pready=1: 2 cycles per transfer (SETUP, ACCESS, SETUP, ...). Penable deasserts for one cycle between transfers.
- Pready is sampled only in ACCESS and is ignored in SETUP.
- Simultaneous Pready=1 and rempty falling in ACCESS: that entry is captured without passing through IDLE.
- Timeout (macro on): a cycle counter clears on SETUP entry and increments each ACCESS cycle with Pready=0.
  - On the cycle where the count equals TO_CYCLES-1 with Pready still 0: Psel/Penable drop next edge and timeout_err=1 for one cycle.
  - No rdata_valid follows. State returns to IDLE (no pop in that cycle).
  - Pready=1 on that same cycle counts as normal completion.

## Configuration
- APB_SCHED_TIMEOUT_EN defined: timeout counter and abort path present as above.
- Undefined: ACCESS waits indefinitely for Pready. The counter is not built and timeout_err is tied 0 (port kept).

## Structure
- Package apb_bridge_pkg:
  - state enum (IDLE, SETUP, ACCESS, DERR)
  - ADDR_W=32 and DATA_W=32
  - default NSLV/SLV_SHIFT
- Sub-module apb_addr_decode: combinational; fifo_addr to {hit, one-hot select}. Parameterised by NSLV, SLV_SHIFT, BASE_HI.
- FSM, capture registers and timeout counter live in apb_xfer_scheduler.

## Test plan
- Single write: FIFO holds {addr 0x4000_1010, data 0xA5A5_0001, write}, Pready=1.
  - rinc for 1 cycle, then Psel=4'b0010 for 2 cycles, Penable in the 2nd, Pdata=0xA5A5_0001.
  - Returns to IDLE, no rdata_valid.
- Read with 3 wait states: read of 0x4000_3000, Pready low for 3 ACCESS cycles, Prdata=0x1234_5678 when high.
  - Psel=4'b1000 for 5 cycles, rdata_out=0x1234_5678, one rdata_valid pulse.
- Back-to-back: 4 queued writes to slaves 0..3, Pready=1.
  - 8 cycles of SETUP/ACCESS alternation, exactly 4 rinc pulses, slave order preserved.
- Decode miss: entry 0x5000_0000.
  - One rinc, decode_err pulse, Psel stays 0.
  - The following valid entry executes normally.
- Reset mid-ACCESS: Preset=1 during the 2nd ACCESS wait cycle.
  - All outputs 0 next edge, state IDLE, no rdata_valid.
- Timeout (macro on, TO_CYCLES=16): Pready held 0.
  - timeout_err pulses after 16 ACCESS cycles, Psel drops.
  - Next queued entry proceeds. Macro off: the transfer stays in ACCESS indefinitely.
